jstk_spi_responder: RTL and testbench
=====================================

# jstk_spi_responder

SPI slave that emulates the PmodJSTK joystick on the far end of the link driven by `PmodJSTK`. It receives the 5-byte master frame, returns X position, Y position and button status in the PmodJSTK frame format, and decodes the LED command from the first received byte. It serves as a synthesizable joystick stand-in for bench and loopback testing of the game top level. It also lets a second board act as a joystick.

## Interface
- `SYNC_STAGES`, default 2: flip-flop stages on each SPI input (min 2).
- `NUM_BYTES`, default 5: bytes per frame.
- `board_clk` input 1: system clock; all logic is in this domain.
- `reset` input 1: asynchronous, active-high.
- `ss` input 1: slave select, active low, asynchronous to `board_clk`.
- `sclk` input 1: SPI clock, mode 0, asynchronous.
- `mosi` input 1: master data, MSB first.
- `miso` output 1: slave data, MSB first.
- `miso_oe` output 1: high while the frame is selected; the top level tristates `miso` when low.
- `x_pos` input 10: X position to report.
- `y_pos` input 10: Y position to report.
- `buttons` input 3: {btn2, btn1, trigger}.
- `leds` output 2: LED bits from the last valid command byte.
- `cmd_valid` output 1: one-cycle pulse when a command byte with prefix 6'b100000 is accepted.
- `frame_done` output 1: one-cycle pulse when `ss` rises after exactly `NUM_BYTES`×8 bits.
- `frame_err` output 1: one-cycle pulse when `ss` rises after any other bit count.

## Operation
- Input conditioning: `ss`, `sclk` and `mosi` each pass through a `SYNC_STAGES` synchronizer. Edges are detected on the synchronized `ss` and `sclk`.
- Frame snapshot: on `ss` falling, latch the 5 transmit bytes.
  - Byte 0: `x_pos[7:0]`.
  - Byte 1: {6'b0, `x_pos[9:8]`}.
  - Byte 2: `y_pos[7:0]`.
  - Byte 3: {6'b0, `y_pos[9:8]`}.
  - Byte 4: {5'b0, `buttons`}.
  - Inputs that change mid-frame do not affect the frame in flight.
- FSM states:
  - IDLE: `miso_oe`=0, `miso`=0. On `ss` fall: take the snapshot, load byte 0 into the tx shifter, drive its MSB, clear the bit count (3b) and byte index (3b), go to SHIFT.
  - SHIFT, on `sclk` rise: shift the synchronized `mosi` into the rx shifter and increment the bit count.
  - SHIFT, on `sclk` fall: if bit count ≠ 0, drive the next tx bit.
  - SHIFT, when bit count wraps 7→0 (after the 8th rise): increment the byte index. The following `sclk` fall drives the MSB of the next byte. If this was byte 0 and rx[7:2]==6'b100000, update `leds`←rx[1:0] and pulse `cmd_valid`. A byte 0 without that prefix leaves `leds` unchanged.
  - SHIFT, when the byte index reaches `NUM_BYTES`: go to HOLD.
  - HOLD: `miso`=0. Extra `sclk` edges are ignored.
  - From SHIFT or HOLD, on `ss` rise: return to IDLE. Pulse `frame_done` if in HOLD with no extra `sclk` rise, otherwise pulse `frame_err`.
- Simultaneous `ss` rise and `sclk` edge in the same cycle: `ss` wins and the edge is discarded.
- `reset` mid-frame: all state clears immediately. After `reset` release, the responder waits for a fresh `ss` fall; a frame already in progress is ignored until `ss` goes high.
- Reset values: `miso`=0, `miso_oe`=0, `leds`=2'b00, `cmd_valid`=0, `frame_done`=0, `frame_err`=0, FSM=IDLE.

## Timing
- Edge-to-action latency is `SYNC_STAGES`+1 `board_clk` cycles from any SPI pin transition.
- `miso` is valid no later than `SYNC_STAGES`+2 cycles after `sclk` fall. Required: `sclk` high and low phases are each ≥ `SYNC_STAGES`+3 cycles, and ss-fall to first `sclk` rise is ≥ `SYNC_STAGES`+3 cycles. The `PmodJSTK` master's ~66 kHz `sclk` meets this with large margin.
- `cmd_valid` fires `SYNC_STAGES`+2 cycles after the 8th `sclk` rise.
- `frame_done` and `frame_err` fire `SYNC_STAGES`+2 cycles after `ss` rise.
- All outputs are registered.

## Structure
- `jstk_pkg`:
  - `JSTK_NUM_BYTES`=5.
  - `JSTK_CMD_PREFIX`=6'b100000.
  - FSM state encoding {IDLE, SHIFT, HOLD}.
  - Byte-index names.
- Sub-module `sync_edge`: parameterized synchronizer with rise and fall pulse outputs. Instantiated for `ss` and `sclk`. `mosi` uses a synchronizer only, same depth, so it stays aligned with `sclk`.

## Test plan
- Full frame: `x_pos`=10'h2A5, `y_pos`=10'h1C3, `buttons`=3'b101, master sends 8'h83,0,0,0,0 -> master receives A5,02,C3,01,05; `leds`=2'b11; one `cmd_valid`; one `frame_done`.
- Mid-frame change: change `x_pos` to 10'h000 after byte 1 -> frame still returns A5,02; next frame returns 00,00.
- Bad command: byte 0 = 8'h43 -> `leds` unchanged, no `cmd_valid`, data still returned, `frame_done` pulses.
- Abort: `ss` rises after 13 bits -> one `frame_err`, `miso_oe`=0; a subsequent full frame succeeds.
- Overrun: 48 `sclk` cycles in one frame -> bytes 5 onward read 0, `frame_err` pulses.
- Reset mid-frame: assert `reset` during byte 2 -> all outputs at reset values; frame ignored until `ss` high; next frame correct with `leds`=2'b00 until a new command is accepted.

Source files
------------

// File: rtl/jstk_pkg.sv
// Shared constants, FSM encoding and transmit-byte layout for the PmodJSTK responder.
package jstk_pkg;

  localparam int           JSTK_NUM_BYTES  = 5;
  localparam logic [5:0]   JSTK_CMD_PREFIX = 6'b100000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } jstk_state_e;

  // Byte positions within the returned frame.
  localparam logic [2:0] BYTE_X_LO = 3'd0;
  localparam logic [2:0] BYTE_X_HI = 3'd1;
  localparam logic [2:0] BYTE_Y_LO = 3'd2;
  localparam logic [2:0] BYTE_Y_HI = 3'd3;
  localparam logic [2:0] BYTE_BTN  = 3'd4;

  // Content of transmit byte idx; positions past the frame read as zero.
  function automatic logic [7:0] jstk_tx_byte(input logic [2:0] idx,
                                              input logic [9:0] x,
                                              input logic [9:0] y,
                                              input logic [2:0] btn);
    case (idx)
      BYTE_X_LO: return x[7:0];
      BYTE_X_HI: return {6'b0, x[9:8]};
      BYTE_Y_LO: return y[7:0];
      BYTE_Y_HI: return {6'b0, y[9:8]};
      BYTE_BTN:  return {5'b0, btn};
      default:   return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchronizer for an asynchronous pin with rise/fall pulse outputs.
// Flops clear to 0 so that a pin already low at reset release never looks
// like a falling edge; a slave select held low mid-frame is therefore ignored
// until it has gone high and fallen again.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic board_clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the pin through the synchronizer and keep the previous synchronized value.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/jstk_spi_responder.sv
// SPI mode-0 slave emulating the PmodJSTK: returns X, Y and button bytes,
// decodes the LED command from the first received byte.
// Interface handshake: the frame is bracketed by ss low; data moves one bit per
// sclk period, mosi captured on sclk rise, miso updated after sclk fall.
module jstk_spi_responder
  import jstk_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_BYTES   = JSTK_NUM_BYTES
) (
  input  logic       board_clk,
  input  logic       reset,
  input  logic       ss,
  input  logic       sclk,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic [2:0] buttons,
  output logic [1:0] leds,
  output logic       cmd_valid,
  output logic       frame_done,
  output logic       frame_err,
  output logic [1:0] dbg_state
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_BYTES);

  logic ss_s, ss_rise, ss_fall;
  logic sclk_s, sclk_rise, sclk_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s;

  jstk_state_e state_q;
  logic [7:0]  tx_q;
  logic [6:0]  rx_q;
  logic [2:0]  bit_cnt_q;
  logic [2:0]  byte_idx_q;
  logic        overrun_q;
  logic [9:0]  x_snap_q;
  logic [9:0]  y_snap_q;
  logic [2:0]  btn_snap_q;
  logic        miso_q;
  logic        miso_oe_q;
  logic [1:0]  leds_q;
  logic        cmd_valid_q;
  logic        frame_done_q;
  logic        frame_err_q;

  logic [7:0]  rx_next;
  logic [2:0]  next_idx;
  logic [7:0]  first_byte;
  logic [7:0]  next_byte;

  sync_edge #(.STAGES(SYNC_STAGES)) u_ss_sync (
    .board_clk (board_clk),
    .reset     (reset),
    .d_i       (ss),
    .q_o       (ss_s),
    .rise_o    (ss_rise),
    .fall_o    (ss_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .board_clk (board_clk),
    .reset     (reset),
    .d_i       (sclk),
    .q_o       (sclk_s),
    .rise_o    (sclk_rise),
    .fall_o    (sclk_fall)
  );

  // Same depth as the sclk path so mosi lines up with the detected rise.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) mosi_sync_q <= '0;
    else       mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
  end

  assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
  assign rx_next    = {rx_q, mosi_s};
  assign next_idx   = byte_idx_q + 3'd1;
  assign first_byte = jstk_tx_byte(BYTE_X_LO, x_pos, y_pos, buttons);
  assign next_byte  = jstk_tx_byte(next_idx, x_snap_q, y_snap_q, btn_snap_q);

  // Frame FSM: snapshot on ss fall, bit shifting in SHIFT, overrun tracking in HOLD.
  // A slave-select rise takes priority over any sclk edge seen in the same cycle.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      tx_q         <= '0;
      rx_q         <= '0;
      bit_cnt_q    <= '0;
      byte_idx_q   <= '0;
      overrun_q    <= 1'b0;
      x_snap_q     <= '0;
      y_snap_q     <= '0;
      btn_snap_q   <= '0;
      miso_q       <= 1'b0;
      miso_oe_q    <= 1'b0;
      leds_q       <= 2'b00;
      cmd_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      cmd_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          miso_q    <= 1'b0;
          miso_oe_q <= 1'b0;
          if (ss_fall) begin
            x_snap_q   <= x_pos;
            y_snap_q   <= y_pos;
            btn_snap_q <= buttons;
            tx_q       <= first_byte;
            miso_q     <= first_byte[7];
            miso_oe_q  <= 1'b1;
            bit_cnt_q  <= '0;
            byte_idx_q <= '0;
            overrun_q  <= 1'b0;
            state_q    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (ss_rise) begin
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            frame_err_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else if (sclk_rise) begin
            rx_q      <= rx_next[6:0];
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              byte_idx_q <= next_idx;
              tx_q       <= next_byte;
              if (byte_idx_q == BYTE_X_LO && rx_next[7:2] == JSTK_CMD_PREFIX) begin
                leds_q      <= rx_next[1:0];
                cmd_valid_q <= 1'b1;
              end
              if (next_idx == LAST_IDX) begin
                miso_q  <= 1'b0;
                state_q <= ST_HOLD;
              end
            end
          end else if (sclk_fall) begin
            // Count 0 means a byte boundary: present the freshly loaded MSB.
            if (bit_cnt_q != 3'd0) begin
              tx_q   <= {tx_q[6:0], 1'b0};
              miso_q <= tx_q[6];
            end else begin
              miso_q <= tx_q[7];
            end
          end
        end
        ST_HOLD: begin
          miso_q <= 1'b0;
          if (ss_rise) begin
            miso_oe_q    <= 1'b0;
            frame_done_q <= ~overrun_q;
            frame_err_q  <= overrun_q;
            state_q      <= ST_IDLE;
          end else if (sclk_rise) begin
            overrun_q <= 1'b1;
          end
        end
        default: begin
          miso_q    <= 1'b0;
          miso_oe_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign miso       = miso_q;
  assign miso_oe    = miso_oe_q;
  assign leds       = leds_q;
  assign cmd_valid  = cmd_valid_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign dbg_state  = state_q;

  // The synchronized levels themselves are only consumed through their edges.
  logic unused_levels;
  assign unused_levels = ss_s ^ sclk_s;

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Directed bench for jstk_spi_responder: drives SPI mode-0 frames and checks
// returned bytes, LED decode and frame status pulses.
module tb_jstk_spi_responder;

  logic       board_clk;
  logic       reset;
  logic       ss;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic [2:0] buttons;
  logic [1:0] leds;
  logic       cmd_valid;
  logic       frame_done;
  logic       frame_err;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int n_cmd  = 0;
  int n_done = 0;
  int n_err  = 0;
  int c0, d0, e0;
  logic [7:0]  exp_q[$];
  logic [63:0] got;
  logic        b;

  jstk_spi_responder dut (
    .board_clk  (board_clk),
    .reset      (reset),
    .ss         (ss),
    .sclk       (sclk),
    .mosi       (mosi),
    .miso       (miso),
    .miso_oe    (miso_oe),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .buttons    (buttons),
    .leds       (leds),
    .cmd_valid  (cmd_valid),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .dbg_state  (dbg_state)
  );

  // Clock
  initial board_clk = 1'b0;
  always #5 board_clk = ~board_clk;

  // Pulse counters, sampled away from the active edge
  always @(negedge board_clk) begin
    if (cmd_valid)  n_cmd  <= n_cmd + 1;
    if (frame_done) n_done <= n_done + 1;
    if (frame_err)  n_err  <= n_err + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge board_clk);
    @(negedge board_clk);
  endtask

  // Driver tasks
  task automatic spi_begin();
    ss = 1'b0;
    wait_cycles(8);
  endtask

  task automatic spi_bit(input logic bi, output logic bo);
    mosi = bi;
    wait_cycles(8);
    bo   = miso;
    sclk = 1'b1;
    wait_cycles(8);
    sclk = 1'b0;
  endtask

  task automatic spi_end();
    wait_cycles(8);
    ss = 1'b1;
    wait_cycles(10);
  endtask

  task automatic xfer(input int nbits, input logic [63:0] mo, output logic [63:0] mi);
    logic bo;
    mi = '0;
    spi_begin();
    for (int i = 0; i < nbits; i++) begin
      spi_bit(mo[nbits-1-i], bo);
      mi = {mi[62:0], bo};
    end
    spi_end();
  endtask

  // Scoreboard: compare received bytes against the expected queue
  task automatic check_bytes(input string tag, input logic [63:0] g, input int nbytes);
    logic [7:0] e;
    for (int k = 0; k < nbytes; k++) begin
      if (exp_q.size() == 0) begin
        chk({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("%s_byte%0d", tag, k), 64'(g[(nbytes-1-k)*8 +: 8]), 64'(e));
      end
    end
  endtask

  task automatic snap_counts();
    c0 = n_cmd;
    d0 = n_done;
    e0 = n_err;
  endtask

  initial begin
    reset = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
    x_pos = 10'h2A5; y_pos = 10'h1C3; buttons = 3'b101;
    wait_cycles(5);
    chk("rst_miso", 64'(miso), 64'd0);
    chk("rst_miso_oe", 64'(miso_oe), 64'd0);
    chk("rst_leds", 64'(leds), 64'd0);
    chk("rst_pulses", 64'({cmd_valid, frame_done, frame_err}), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    reset = 1'b0;
    wait_cycles(10);

    // Full frame with LED command 0x83
    snap_counts();
    exp_q.push_back(8'hA5); exp_q.push_back(8'h02); exp_q.push_back(8'hC3);
    exp_q.push_back(8'h01); exp_q.push_back(8'h05);
    xfer(40, 64'h83_00_00_00_00, got);
    check_bytes("full", got, 5);
    chk("full_leds", 64'(leds), 64'b11);
    chk("full_cmd", 64'(n_cmd - c0), 64'd1);
    chk("full_done", 64'(n_done - d0), 64'd1);
    chk("full_err", 64'(n_err - e0), 64'd0);
    chk("full_oe_after", 64'(miso_oe), 64'd0);

    // x_pos changes after byte 1: frame in flight keeps the snapshot
    snap_counts();
    exp_q.push_back(8'hA5); exp_q.push_back(8'h02); exp_q.push_back(8'hC3);
    exp_q.push_back(8'h01); exp_q.push_back(8'h05);
    got = '0;
    spi_begin();
    for (int i = 0; i < 40; i++) begin
      if (i == 16) begin
        x_pos = 10'h000;
        chk("mid_oe", 64'(miso_oe), 64'd1);
        chk("mid_state", 64'(dbg_state), 64'd1);
      end
      spi_bit(1'b0, b);
      got = {got[62:0], b};
    end
    spi_end();
    check_bytes("midchg", got, 5);
    chk("midchg_leds", 64'(leds), 64'b11);
    chk("midchg_done", 64'(n_done - d0), 64'd1);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'hC3);
    exp_q.push_back(8'h01); exp_q.push_back(8'h05);
    xfer(40, 64'h0, got);
    check_bytes("after_chg", got, 5);

    // Bad command prefix: LEDs untouched, data still returned
    x_pos = 10'h3FF; y_pos = 10'h000; buttons = 3'b010;
    snap_counts();
    exp_q.push_back(8'hFF); exp_q.push_back(8'h03); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h02);
    xfer(40, 64'h43_00_00_00_00, got);
    check_bytes("badcmd", got, 5);
    chk("badcmd_leds", 64'(leds), 64'b11);
    chk("badcmd_cmd", 64'(n_cmd - c0), 64'd0);
    chk("badcmd_done", 64'(n_done - d0), 64'd1);

    // Abort after 13 bits: FF then top 5 bits of 0x03
    snap_counts();
    xfer(13, 64'h0, got);
    chk("abort_bits", got, 64'h1FE0);
    chk("abort_err", 64'(n_err - e0), 64'd1);
    chk("abort_done", 64'(n_done - d0), 64'd0);
    chk("abort_oe", 64'(miso_oe), 64'd0);
    chk("abort_state", 64'(dbg_state), 64'd0);
    snap_counts();
    exp_q.push_back(8'hFF); exp_q.push_back(8'h03); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h02);
    xfer(40, 64'h81_00_00_00_00, got);
    check_bytes("post_abort", got, 5);
    chk("post_abort_leds", 64'(leds), 64'b01);
    chk("post_abort_done", 64'(n_done - d0), 64'd1);
    chk("post_abort_cmd", 64'(n_cmd - c0), 64'd1);

    // Overrun: 48 clocks, bytes past the frame read zero
    snap_counts();
    exp_q.push_back(8'hFF); exp_q.push_back(8'h03); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h02); exp_q.push_back(8'h00);
    xfer(48, 64'h0, got);
    check_bytes("overrun", got, 6);
    chk("overrun_err", 64'(n_err - e0), 64'd1);
    chk("overrun_done", 64'(n_done - d0), 64'd0);

    // Reset during byte 2
    snap_counts();
    spi_begin();
    for (int i = 0; i < 20; i++) spi_bit(1'b0, b);
    reset = 1'b1;
    wait_cycles(2);
    chk("midrst_miso", 64'(miso), 64'd0);
    chk("midrst_oe", 64'(miso_oe), 64'd0);
    chk("midrst_leds", 64'(leds), 64'd0);
    chk("midrst_state", 64'(dbg_state), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) spi_bit(1'b1, b);
    chk("ignored_oe", 64'(miso_oe), 64'd0);
    chk("ignored_state", 64'(dbg_state), 64'd0);
    chk("ignored_miso", 64'(miso), 64'd0);
    spi_end();
    chk("ignored_done", 64'(n_done - d0), 64'd0);
    chk("ignored_err", 64'(n_err - e0), 64'd0);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h03); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h02);
    xfer(40, 64'h0, got);
    check_bytes("post_rst", got, 5);
    chk("post_rst_leds", 64'(leds), 64'b00);
    chk("post_rst_done", 64'(n_done - d0), 64'd1);
    xfer(40, 64'h82_00_00_00_00, got);
    chk("new_cmd_leds", 64'(leds), 64'b10);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
